deserializador_com: RTL

DESERIALIZADOR_COM -- requirements
Module: deserializador_com

---
 rtl/deserializador_com_pkg.sv | 14 +
 rtl/deserializador_com_rx_shift_window.sv | 27 ++
 rtl/deserializador_com.sv | 123 ++++++++++++
 3 files changed

// File: rtl/deserializador_com_pkg.sv
// Shared definitions for the serial link: comma symbol, lock threshold and FSM state codes.
// Also used by the upstream paralelo-serial stage so both ends agree on the idle symbol.
package deserializador_com_pkg;

  localparam logic [7:0] COM_SYM       = 8'hBC;
  localparam int         BC_NEEDED_DEF = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_HUNT    = 2'd0;
  localparam state_t ST_LOCKING = 2'd1;
  localparam state_t ST_ACTIVE  = 2'd2;

endpackage

// File: rtl/deserializador_com_rx_shift_window.sv
// Serial-in shift register presenting the byte that ends at the current bit.
// Seven past bits are stored; the live data_in completes the 8-bit window.
module rx_shift_window (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] window
);

  logic [6:0] sr_q;
  logic [6:0] sr_d;

  always_comb begin
    sr_d = {sr_q[5:0], data_in};
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr_q <= 7'd0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign window = {sr_q, data_in};

endmodule

// File: rtl/deserializador_com.sv
// Comma-aligned serial-to-parallel receiver: hunts for COM at any bit offset,
// locks after BC_NEEDED aligned COMs, then emits one byte every 8 clk_32f cycles.
//
// state      | meaning
// HUNT       | searching every bit position for COM
// LOCKING    | counting aligned COMs at byte boundaries
// ACTIVE     | locked; publishing a byte at each boundary
module deserializador_com
  import deserializador_com_pkg::*;
#(
  parameter logic [7:0] COM       = COM_SYM,
  parameter int         BC_NEEDED = BC_NEEDED_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       inserter
);

  localparam int             BCW    = $clog2(BC_NEEDED + 1);
  localparam logic [BCW-1:0] BC_MAX = BCW'(BC_NEEDED);

  logic [7:0]     window;
  state_t         state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BCW-1:0] bc_cnt_q, bc_cnt_d;
  logic [BCW-1:0] bc_inc;
  logic [7:0]     data_out_q, data_out_d;
  logic           valid_q, valid_d;
  logic           strobe_q, strobe_d;
  logic           ins_q, ins_d;
  logic           is_com;
  logic           boundary;

  rx_shift_window u_window (
    .clk_32f (clk_32f),
    .reset   (reset),
    .data_in (data_in),
    .window  (window)
  );

  assign is_com   = (window == COM);
  assign boundary = (bit_cnt_q == 3'd7);
  assign bc_inc   = (bc_cnt_q == BC_MAX) ? bc_cnt_q : bc_cnt_q + BCW'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    bc_cnt_d   = bc_cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
    ins_d      = ins_q;
    case (state_q)
      ST_HUNT: begin
        if (is_com) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = BCW'(1);
          if (BC_NEEDED <= 1) begin
            state_d = ST_ACTIVE;
            ins_d   = 1'b1;
          end else begin
            state_d = ST_LOCKING;
          end
        end
      end
      ST_LOCKING: begin
        if (boundary) begin
          if (is_com) begin
            bc_cnt_d = bc_inc;
            if (bc_inc == BC_MAX) begin
              state_d = ST_ACTIVE;
              ins_d   = 1'b1;
            end
          end else begin
            // Failing byte is consumed here; hunting resumes on the next bit.
            bc_cnt_d = '0;
            state_d  = ST_HUNT;
          end
        end
      end
      ST_ACTIVE: begin
        if (boundary) begin
          data_out_d = window;
          valid_d    = !is_com;
          strobe_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= ST_HUNT;
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= '0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      ins_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      ins_q      <= ins_d;
    end
  end

  assign data_out    = data_out_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign inserter    = ins_q;

endmodule
